// File: rtl/rx_decim_frontend.sv
// AD9862 receive front end: registers both ADC streams, then averages each over
// power-of-two windows and presents 16-bit samples with a strobe for rx_buffer.
module rx_decim_frontend #(
    parameter int ADC_W    = 12,
    parameter int OUT_W    = 16,
    parameter int MAX_LOG2 = 7
) (
    input  logic             rx_clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             test_mode,
    input  logic [2:0]       decim_log2,
    input  logic [ADC_W-1:0] rx_a_a,
    input  logic [ADC_W-1:0] rx_a_b,
    output logic [OUT_W-1:0] ch_0,
    output logic [OUT_W-1:0] ch_1,
    output logic [OUT_W-1:0] ch_2,
    output logic [OUT_W-1:0] ch_3,
    output logic             rxstrobe,
    output logic             window_busy
);

    localparam int ACC_W = ADC_W + MAX_LOG2;
    localparam int PAD_W = OUT_W - ADC_W;

    logic                en_reg;
    logic [MAX_LOG2-1:0] cnt_reg;
    logic [MAX_LOG2-1:0] cnt_next;
    logic [2:0]          cur_log2_reg;
    logic [2:0]          eff_log2;
    logic [MAX_LOG2:0]   win_len;
    logic                window_end;
    logic [OUT_W-1:0]    ramp_reg;
    logic [OUT_W-1:0]    ch_0_reg;
    logic [OUT_W-1:0]    ch_1_reg;
    logic [OUT_W-1:0]    ch_3_reg;
    logic                strobe_reg;

    logic [ADC_W-1:0]    adc_pins [2];
    logic [OUT_W-1:0]    avg_out  [2];

    assign adc_pins[0] = rx_a_a;
    assign adc_pins[1] = rx_a_b;

    // The exponent is picked up at window start; mid-window it stays frozen so a
    // change only affects the next window. With N = 1 every cycle is a start.
    always_comb begin
        eff_log2   = (cnt_reg == '0) ? decim_log2 : cur_log2_reg;
        win_len    = (MAX_LOG2 + 1)'(1) << eff_log2;
        window_end = en_reg && ({1'b0, cnt_reg} == (win_len - 1'b1));
        cnt_next   = '0;
        if (en_reg && !window_end) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            logic signed [ADC_W-1:0] adc_reg;
            logic signed [ACC_W-1:0] acc_reg;
            logic signed [ACC_W-1:0] sum;
            logic signed [ADC_W-1:0] avg_bits;

            // The final sample of a window is folded in combinationally so the
            // average is ready on the same edge that closes the window.
            assign sum      = acc_reg + {{MAX_LOG2{adc_reg[ADC_W-1]}}, adc_reg};
            assign avg_bits = ADC_W'(sum >>> eff_log2);
            assign avg_out[gi] = {avg_bits, {PAD_W{1'b0}}};

            always_ff @(posedge rx_clk or negedge reset_n) begin
                if (!reset_n) begin
                    adc_reg <= '0;
                    acc_reg <= '0;
                end else begin
                    adc_reg <= adc_pins[gi];
                    if (!en_reg || window_end) begin
                        acc_reg <= '0;
                    end else begin
                        acc_reg <= sum;
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge rx_clk or negedge reset_n) begin
        if (!reset_n) begin
            en_reg       <= 1'b0;
            cnt_reg      <= '0;
            cur_log2_reg <= '0;
            ramp_reg     <= '0;
            ch_0_reg     <= '0;
            ch_1_reg     <= '0;
            ch_3_reg     <= '0;
            strobe_reg   <= 1'b0;
        end else begin
            en_reg       <= enable;
            cnt_reg      <= cnt_next;
            cur_log2_reg <= eff_log2;
            strobe_reg   <= window_end;
            if (window_end) begin
                ch_3_reg <= ch_3_reg + 1'b1;
                if (test_mode) begin
                    ch_0_reg <= ramp_reg;
                    ch_1_reg <= ~ramp_reg;
                    ramp_reg <= ramp_reg + 1'b1;
                end else begin
                    ch_0_reg <= avg_out[0];
                    ch_1_reg <= avg_out[1];
                end
            end
        end
    end

    assign ch_0        = ch_0_reg;
    assign ch_1        = ch_1_reg;
    assign ch_2        = '0;
    assign ch_3        = ch_3_reg;
    assign rxstrobe    = strobe_reg;
    assign window_busy = (cnt_reg != '0);

endmodule

// File: tb/tb_rx_decim_frontend.sv
// Bench for rx_decim_frontend: directed table, hand-built corner sequences and a
// randomized run, all checked against a window-list model of the averager.
module tb_rx_decim_frontend;

    logic        rx_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        test_mode = 1'b0;
    logic [2:0]  decim_log2 = 3'd0;
    logic [11:0] rx_a_a = 12'd0;
    logic [11:0] rx_a_b = 12'd0;
    logic [15:0] ch_0, ch_1, ch_2, ch_3;
    logic        rxstrobe, window_busy;

    rx_decim_frontend dut (
        .rx_clk      (rx_clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .test_mode   (test_mode),
        .decim_log2  (decim_log2),
        .rx_a_a      (rx_a_a),
        .rx_a_b      (rx_a_b),
        .ch_0        (ch_0),
        .ch_1        (ch_1),
        .ch_2        (ch_2),
        .ch_3        (ch_3),
        .rxstrobe    (rxstrobe),
        .window_busy (window_busy)
    );

    always #5 rx_clk = ~rx_clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: samples of the open window kept as a list of integers.
    int          win_a[$];
    int          win_b[$];
    int          m_n;
    logic [15:0] m_ch0, m_ch1, m_ch3, m_ramp;
    logic        m_strobe;
    logic        p_en;
    logic [11:0] p_a, p_b;

    typedef struct {
        logic        en;
        logic [2:0]  lg;
        logic [11:0] a;
        logic [11:0] b;
        logic        stb;
        logic [15:0] c0;
        logic [15:0] c1;
        logic [15:0] c3;
        logic        busy;
    } vec_t;

    vec_t tbl[13];

    function automatic int floor_avg(input int q[$], input int n);
        int sum = 0;
        int r;
        foreach (q[i]) sum += q[i];
        r = sum % n;
        if (r < 0) r += n;
        return (sum - r) / n;
    endfunction

    function automatic logic [15:0] to_out(input int avg);
        logic [31:0] v;
        v = avg;
        return {v[11:0], 4'h0};
    endfunction

    task automatic model_reset();
        win_a.delete();
        win_b.delete();
        m_n = 1;
        m_ch0 = '0; m_ch1 = '0; m_ch3 = '0; m_ramp = '0;
        m_strobe = 1'b0;
        p_en = 1'b0; p_a = '0; p_b = '0;
    endtask

    // Applied at each rising edge: p_* hold what the DUT captured one edge
    // earlier; decim_log2 and test_mode are used as currently driven.
    task automatic model_edge();
        m_strobe = 1'b0;
        if (p_en) begin
            if (win_a.size() == 0) m_n = 1 << decim_log2;
            win_a.push_back(int'($signed(p_a)));
            win_b.push_back(int'($signed(p_b)));
            if (win_a.size() == m_n) begin
                m_strobe = 1'b1;
                m_ch3 = m_ch3 + 16'd1;
                if (test_mode) begin
                    m_ch0 = m_ramp;
                    m_ch1 = ~m_ramp;
                    m_ramp = m_ramp + 16'd1;
                end else begin
                    m_ch0 = to_out(floor_avg(win_a, m_n));
                    m_ch1 = to_out(floor_avg(win_b, m_n));
                end
                win_a.delete();
                win_b.delete();
            end
        end else begin
            win_a.delete();
            win_b.delete();
        end
        p_en = enable;
        p_a = rx_a_a;
        p_b = rx_a_b;
    endtask

    task automatic check_model();
        logic m_busy;
        m_busy = (win_a.size() != 0);
        vectors++;
        if (rxstrobe !== m_strobe || ch_0 !== m_ch0 || ch_1 !== m_ch1 ||
            ch_2 !== 16'h0 || ch_3 !== m_ch3 || window_busy !== m_busy) begin
            miscompares++;
            $display("FAIL model t=%0t: got stb=%b ch0=%h ch1=%h ch2=%h ch3=%h busy=%b, want stb=%b ch0=%h ch1=%h ch2=0000 ch3=%h busy=%b",
                     $time, rxstrobe, ch_0, ch_1, ch_2, ch_3, window_busy,
                     m_strobe, m_ch0, m_ch1, m_ch3, m_busy);
        end
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic cycle(input logic en, input logic tm, input logic [2:0] lg,
                         input logic [11:0] a, input logic [11:0] b);
        enable = en; test_mode = tm; decim_log2 = lg; rx_a_a = a; rx_a_b = b;
        @(posedge rx_clk);
        if (reset_n) model_edge();
        else model_reset();
        #1;
        check_model();
    endtask

    initial begin
        logic [15:0] cap0, cap1;
        int          stb_cnt;
        int          stb_at[$];
        logic [15:0] ramp0[$];
        logic [15:0] ramp1[$];

        tbl[0]  = '{1'b1, 3'd0, 12'h001, 12'hFFF, 1'b0, 16'h0000, 16'h0000, 16'd0, 1'b0};
        tbl[1]  = '{1'b1, 3'd0, 12'h001, 12'hFFF, 1'b1, 16'h0010, 16'hFFF0, 16'd1, 1'b0};
        tbl[2]  = '{1'b1, 3'd0, 12'h001, 12'hFFF, 1'b1, 16'h0010, 16'hFFF0, 16'd2, 1'b0};
        tbl[3]  = '{1'b1, 3'd0, 12'h001, 12'hFFF, 1'b1, 16'h0010, 16'hFFF0, 16'd3, 1'b0};
        tbl[4]  = '{1'b0, 3'd0, 12'h000, 12'h000, 1'b1, 16'h0010, 16'hFFF0, 16'd4, 1'b0};
        tbl[5]  = '{1'b0, 3'd2, 12'h000, 12'h000, 1'b0, 16'h0010, 16'hFFF0, 16'd4, 1'b0};
        tbl[6]  = '{1'b1, 3'd2, 12'h004, 12'h000, 1'b0, 16'h0010, 16'hFFF0, 16'd4, 1'b0};
        tbl[7]  = '{1'b1, 3'd2, 12'h008, 12'h000, 1'b0, 16'h0010, 16'hFFF0, 16'd4, 1'b1};
        tbl[8]  = '{1'b1, 3'd2, 12'h00C, 12'h000, 1'b0, 16'h0010, 16'hFFF0, 16'd4, 1'b1};
        tbl[9]  = '{1'b1, 3'd2, 12'h010, 12'h000, 1'b0, 16'h0010, 16'hFFF0, 16'd4, 1'b1};
        tbl[10] = '{1'b1, 3'd2, 12'h014, 12'h000, 1'b1, 16'h00A0, 16'h0000, 16'd5, 1'b0};
        tbl[11] = '{1'b0, 3'd2, 12'h000, 12'h000, 1'b0, 16'h00A0, 16'h0000, 16'd5, 1'b1};
        tbl[12] = '{1'b0, 3'd2, 12'h000, 12'h000, 1'b0, 16'h00A0, 16'h0000, 16'd5, 1'b0};

        model_reset();
        #1;
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 3'd0, 12'h123, 12'h456);
        check_val("reset_ch0", int'(ch_0), 0);
        check_val("reset_ch3", int'(ch_3), 0);
        check_val("reset_strobe", int'(rxstrobe), 0);
        check_val("reset_busy", int'(window_busy), 0);

        // Directed table: N = 1 streaming then one N = 4 window.
        reset_n = 1'b1;
        for (int i = 0; i < 13; i++) begin
            cycle(tbl[i].en, 1'b0, tbl[i].lg, tbl[i].a, tbl[i].b);
            vectors++;
            if (rxstrobe !== tbl[i].stb || ch_0 !== tbl[i].c0 || ch_1 !== tbl[i].c1 ||
                ch_3 !== tbl[i].c3 || window_busy !== tbl[i].busy) begin
                miscompares++;
                $display("FAIL table[%0d]: got stb=%b ch0=%h ch1=%h ch3=%h busy=%b, want stb=%b ch0=%h ch1=%h ch3=%h busy=%b",
                         i, rxstrobe, ch_0, ch_1, ch_3, window_busy,
                         tbl[i].stb, tbl[i].c0, tbl[i].c1, tbl[i].c3, tbl[i].busy);
            end
        end

        // N = 128 at negative full scale.
        stb_cnt = 0; cap0 = '0;
        for (int k = 1; k <= 129; k++) begin
            cycle(k <= 128, 1'b0, 3'd7, 12'h800, 12'h800);
            if (rxstrobe) begin stb_cnt++; cap0 = ch_0; end
        end
        check_val("n128_fullscale_ch0", int'(cap0), 16'h8000);
        check_val("n128_strobe_count", stb_cnt, 1);

        // N = 128 alternating extremes: mean -0.5 floors to -1.
        stb_cnt = 0; cap0 = '0;
        for (int k = 1; k <= 129; k++) begin
            cycle(k <= 128, 1'b0, 3'd7, (k % 2 == 1) ? 12'h7FF : 12'h800, 12'h000);
            if (rxstrobe) begin stb_cnt++; cap0 = ch_0; end
        end
        check_val("n128_floor_ch0", int'(cap0), 16'hFFF0);
        check_val("n128_floor_count", stb_cnt, 1);

        // Exponent change 3 -> 1 while five samples are in the window.
        stb_at.delete();
        for (int k = 1; k <= 15; k++) begin
            cycle(k <= 14, 1'b0, (k < 7) ? 3'd3 : 3'd1, 12'($urandom), 12'($urandom));
            if (rxstrobe) stb_at.push_back(k);
        end
        check_val("log2_change_count", stb_at.size(), 4);
        if (stb_at.size() == 4) begin
            check_val("log2_change_first", stb_at[0], 9);
            check_val("log2_change_second", stb_at[1], 11);
            check_val("log2_change_last", stb_at[3], 15);
        end

        // Enable dropped after three samples of an N = 8 window.
        stb_at.delete();
        for (int k = 1; k <= 14; k++) begin
            cycle((k <= 3) || (k >= 6 && k <= 13), 1'b0, 3'd3, 12'($urandom), 12'($urandom));
            if (k == 4) check_val("drop_busy_before", int'(window_busy), 1);
            if (k == 5) check_val("drop_busy_after", int'(window_busy), 0);
            if (rxstrobe) stb_at.push_back(k);
        end
        check_val("reenable_strobes", stb_at.size(), 1);
        if (stb_at.size() == 1) check_val("reenable_strobe_at", stb_at[0], 14);

        // Asynchronous reset in the middle of a window.
        for (int k = 1; k <= 5; k++) cycle(1'b1, 1'b0, 3'd3, 12'h3A5, 12'h5A3);
        check_val("pre_reset_ch3", int'(ch_3 != 16'd0), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check_val("async_reset_ch0", int'(ch_0), 0);
        check_val("async_reset_ch1", int'(ch_1), 0);
        check_val("async_reset_ch3", int'(ch_3), 0);
        check_val("async_reset_busy", int'(window_busy), 0);
        check_val("async_reset_strobe", int'(rxstrobe), 0);
        model_reset();
        cycle(1'b1, 1'b0, 3'd3, 12'h111, 12'h222);
        cycle(1'b1, 1'b0, 3'd3, 12'h111, 12'h222);
        reset_n = 1'b1;
        cycle(1'b0, 1'b0, 3'd1, 12'h000, 12'h000);

        // Ramp pattern with N = 2.
        ramp0.delete(); ramp1.delete();
        for (int k = 1; k <= 9; k++) begin
            cycle(k <= 8, 1'b1, 3'd1, 12'($urandom), 12'($urandom));
            if (rxstrobe) begin ramp0.push_back(ch_0); ramp1.push_back(ch_1); end
        end
        check_val("ramp_strobes", ramp0.size(), 4);
        if (ramp0.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check_val($sformatf("ramp_ch0_%0d", i), int'(ramp0[i]), i);
                check_val($sformatf("ramp_ch1_%0d", i), int'(ramp1[i]), 16'hFFFF - i);
            end
        end

        // Randomized run against the model.
        for (int k = 0; k < 4000; k++) begin
            logic [11:0] ra, rb;
            ra = 12'($urandom);
            rb = 12'($urandom);
            if ($urandom_range(0, 9) == 0) ra = ($urandom_range(0, 1) != 0) ? 12'h7FF : 12'h800;
            if ($urandom_range(0, 9) == 0) rb = ($urandom_range(0, 1) != 0) ? 12'h7FF : 12'h800;
            cycle($urandom_range(0, 99) != 0, $urandom_range(0, 7) == 0,
                  3'($urandom_range(0, 7)), ra, rb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
